// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb : decode-stage register file with write bypass and RAW scoreboard
//
// This is the parametrised successor to the 32x32 register file for the
// pipelined MIPS core. It provides zero-latency reads and writes on the
// rising edge. A per-register busy bit is set when decode issues a producer
// and cleared when writeback retires it.
//
// Parameters
//   DATA_W   register width
//   ADDR_W   address width, NREG = 2**ADDR_W registers
//   N_RD     number of read ports (1..4)
//   ZERO_REG 1 = r0 reads 0, ignores writes and is never marked busy
//   BYPASS   1 = a same-cycle write to a read address is forwarded to that port
//
// Ports
//   i_clk, i_rst_n   clock; asynchronous active-low reset
//   i_raddr          N_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   i_ren            per-port read valid, only used to qualify o_stall
//   o_rdata          N_RD packed read data, port k at [k*DATA_W +: DATA_W]
//   o_rbusy          per-port "address has a pending producer"
//   o_stall          OR over ports of i_ren & o_rbusy
//   i_we/i_waddr/i_wdata        writeback port
//   i_issue/i_issue_addr        destination of the instruction issued by decode
//   o_busy_cnt       registered count of pending registers (0..NREG)
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_RD*ADDR_W-1:0]   i_raddr,
    input  logic [N_RD-1:0]          i_ren,
    output logic [N_RD*DATA_W-1:0]   o_rdata,
    output logic [N_RD-1:0]          o_rbusy,
    output logic                     o_stall,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_issue,
    input  logic [ADDR_W-1:0]        i_issue_addr,
    output logic [ADDR_W:0]          o_busy_cnt
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int          CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              we_eff;

    // Writes to r0 are dropped when it is hard-wired to zero.
    assign we_eff = i_we && !((ZERO_REG != 0) && (i_waddr == '0));

    // -------------------------------------------------------------------------
    // Register array
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_eff) begin
            regs_q[i_waddr] <= i_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard next state. A same-cycle issue beats the retiring write,
    // because the new producer has not written yet.
    // -------------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        cnt_d  = '0;
        for (int unsigned a = 0; a < NREG; a++) begin
            logic set_a;
            logic clr_a;
            set_a = i_issue && (i_issue_addr == ADDR_W'(a))
                    && !((ZERO_REG != 0) && (a == 0));
            clr_a = i_we && (i_waddr == ADDR_W'(a));
            if (set_a) begin
                busy_d[a] = 1'b1;
            end else if (clr_a) begin
                busy_d[a] = 1'b0;
            end
            cnt_d = cnt_d + CNT_W'(busy_d[a]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_busy_cnt = cnt_q;

    // -------------------------------------------------------------------------
    // Read ports (independent, combinational)
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              is_zero;
        logic              wr_hit;
        logic              iss_hit;

        assign ra      = i_raddr[k*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);
        assign wr_hit  = (BYPASS != 0) && i_we && (i_waddr == ra);
        assign iss_hit = i_issue && (i_issue_addr == ra);

        assign o_rdata[k*DATA_W +: DATA_W] = is_zero ? '0 :
                                             wr_hit  ? i_wdata :
                                                       regs_q[ra];

        // When the data is forwarded this cycle, the read does not stall.
        // If a new producer is issued to the same register in the same
        // cycle, the register stays busy and the read still stalls.
        assign o_rbusy[k] = busy_q[ra] & ~(wr_hit & ~iss_hit);
    end

    assign o_stall = |(i_ren & o_rbusy);

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    // Shared stimulus for the default instance (BYPASS=1) and the BYPASS=0 instance
    logic [9:0]  raddr;
    logic [1:0]  ren;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        issue;
    logic [4:0]  issue_addr;

    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rbusy_a, rbusy_b;
    logic        stall_a, stall_b;
    logic [5:0]  cnt_a, cnt_b;

    // Narrow, 4-port instance
    logic [11:0] raddr2;
    logic [3:0]  ren2;
    logic        we2;
    logic [2:0]  waddr2;
    logic [15:0] wdata2;
    logic        issue2;
    logic [2:0]  issue_addr2;
    logic [63:0] rdata2;
    logic [3:0]  rbusy2;
    logic        stall2;
    logic [3:0]  cnt2;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .i_ren(ren),
        .o_rdata(rdata_a), .o_rbusy(rbusy_a), .o_stall(stall_a),
        .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_issue(issue), .i_issue_addr(issue_addr), .o_busy_cnt(cnt_a)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .i_ren(ren),
        .o_rdata(rdata_b), .o_rbusy(rbusy_b), .o_stall(stall_b),
        .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_issue(issue), .i_issue_addr(issue_addr), .o_busy_cnt(cnt_b)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .N_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr2), .i_ren(ren2),
        .o_rdata(rdata2), .o_rbusy(rbusy2), .o_stall(stall2),
        .i_we(we2), .i_waddr(waddr2), .i_wdata(wdata2),
        .i_issue(issue2), .i_issue_addr(issue_addr2), .o_busy_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and samples sit 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; issue = 1'b0; ren = '0;
    endtask

    // Reference model for the narrow instance
    logic [15:0] mreg  [8];
    logic [7:0]  mbusy;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        raddr = '0; ren = '0; we = 1'b0; waddr = '0; wdata = '0;
        issue = 1'b0; issue_addr = '0;
        raddr2 = '0; ren2 = '0; we2 = 1'b0; waddr2 = '0; wdata2 = '0;
        issue2 = 1'b0; issue_addr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // ---------------- reset state ----------------
        raddr = {5'd5, 5'd5};
        #1;
        chk("rst_rdata", rdata_a, 64'h0);
        chk("rst_cnt", cnt_a, 6'd0);
        chk("rst_stall", stall_a, 1'b0);

        // ---------------- async reset mid-operation ----------------
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        issue = 1'b1; issue_addr = 5'd5;
        tick();
        idle();
        raddr = {5'd0, 5'd5}; ren = 2'b01;
        #1;
        chk("pre_rst_r5", rdata_a[31:0], 32'hDEADBEEF);
        chk("pre_rst_cnt", cnt_a, 6'd1);
        chk("pre_rst_stall", stall_a, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_r5", rdata_a[31:0], 32'h0);
        chk("async_rst_cnt", cnt_a, 6'd0);
        chk("async_rst_stall", stall_a, 1'b0);
        chk("async_rst_rbusy", rbusy_a, 2'b00);
        #1;
        rst_n = 1'b1;
        tick();
        idle();

        // ---------------- zero register ----------------
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        issue = 1'b1; issue_addr = 5'd0;
        raddr = {5'd0, 5'd0}; ren = 2'b01;
        #1;
        chk("zero_bypass", rdata_a[31:0], 32'h0);
        chk("zero_rbusy_pre", rbusy_a[0], 1'b0);
        tick();
        idle();
        ren = 2'b01;
        #1;
        chk("zero_rdata", rdata_a[31:0], 32'h0);
        chk("zero_rbusy", rbusy_a[0], 1'b0);
        chk("zero_cnt", cnt_a, 6'd0);
        chk("zero_stall", stall_a, 1'b0);

        // ---------------- bypass vs no bypass ----------------
        we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        tick();
        wdata = 32'hA5A5A5A5; raddr = {5'd0, 5'd7};
        #1;
        chk("byp_on_same", rdata_a[31:0], 32'hA5A5A5A5);
        chk("byp_off_same", rdata_b[31:0], 32'h11111111);
        tick();
        idle();
        #1;
        chk("byp_on_after", rdata_a[31:0], 32'hA5A5A5A5);
        chk("byp_off_after", rdata_b[31:0], 32'hA5A5A5A5);

        // ---------------- RAW hazard on r3 ----------------
        issue = 1'b1; issue_addr = 5'd3;
        tick();
        idle();
        raddr = {5'd3, 5'd0}; ren = 2'b10;
        #1;
        chk("haz_rbusy1", rbusy_a[1], 1'b1);
        chk("haz_stall", stall_a, 1'b1);
        chk("haz_cnt", cnt_a, 6'd1);
        tick();
        tick();
        we = 1'b1; waddr = 5'd3; wdata = 32'h33;
        #1;
        chk("haz_wb_rbusy1", rbusy_a[1], 1'b0);
        chk("haz_wb_stall", stall_a, 1'b0);
        chk("haz_wb_rdata1", rdata_a[63:32], 32'h33);
        chk("haz_nobyp_rbusy1", rbusy_b[1], 1'b1);
        chk("haz_nobyp_stall", stall_b, 1'b1);
        tick();
        idle();
        ren = 2'b10;
        #1;
        chk("haz_done_rbusy1", rbusy_a[1], 1'b0);
        chk("haz_done_cnt", cnt_a, 6'd0);
        chk("haz_done_cnt_b", cnt_b, 6'd0);
        chk("haz_done_rdata_b", rdata_b[63:32], 32'h33);

        // ---------------- re-issue does not double-count ----------------
        issue = 1'b1; issue_addr = 5'd9;
        tick();
        tick();
        issue = 1'b0;
        #1;
        chk("reissue_cnt", cnt_a, 6'd1);

        // ---------------- simultaneous write and issue on r9 ----------------
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        issue = 1'b1; issue_addr = 5'd9;
        raddr = {5'd0, 5'd9}; ren = 2'b01;
        #1;
        chk("sim_rbusy0", rbusy_a[0], 1'b1);
        chk("sim_stall", stall_a, 1'b1);
        tick();
        idle();
        ren = 2'b01;
        #1;
        chk("sim_cnt", cnt_a, 6'd1);
        chk("sim_rbusy_after", rbusy_a[0], 1'b1);
        chk("sim_rdata", rdata_a[31:0], 32'h99);
        we = 1'b1; waddr = 5'd9; wdata = 32'h9A;
        tick();
        idle();
        #1;
        chk("sim_clear_cnt", cnt_a, 6'd0);
        chk("sim_clear_rdata", rdata_a[31:0], 32'h9A);

        // ---------------- narrow 4-port instance ----------------
        for (int i = 0; i < 8; i++) mreg[i] = '0;
        mbusy = '0;
        for (int i = 1; i < 8; i++) begin
            issue2 = 1'b1; issue_addr2 = 3'(i);
            tick();
            mbusy[i] = 1'b1;
        end
        issue2 = 1'b1; issue_addr2 = 3'd0;
        tick();
        issue2 = 1'b0;
        #1;
        chk("c_all_busy_cnt", cnt2, 4'd7);

        for (int cyc = 0; cyc < 1000; cyc++) begin
            logic [15:0] ed;
            logic        eb;
            logic        es;
            logic [3:0]  ec;
            logic [2:0]  a;
            we2 = 1'($urandom_range(0, 1));
            waddr2 = 3'($urandom_range(0, 7));
            wdata2 = 16'($urandom);
            issue2 = ($urandom_range(0, 3) == 0);
            issue_addr2 = 3'($urandom_range(0, 7));
            raddr2 = 12'($urandom);
            ren2 = 4'($urandom);
            #1;
            es = 1'b0;
            for (int k = 0; k < 4; k++) begin
                a = raddr2[k*3 +: 3];
                if (a == 3'd0) ed = '0;
                else if (we2 && waddr2 == a) ed = wdata2;
                else ed = mreg[a];
                eb = mbusy[a] && !(we2 && waddr2 == a && !(issue2 && issue_addr2 == a));
                es = es | (eb & ren2[k]);
                chk("c_rdata", rdata2[k*16 +: 16], ed);
                chk("c_rbusy", rbusy2[k], eb);
            end
            chk("c_stall", stall2, es);
            if (we2 && waddr2 != 3'd0) mreg[waddr2] = wdata2;
            if (issue2 && issue_addr2 != 3'd0) mbusy[issue_addr2] = 1'b1;
            if (we2 && !(issue2 && issue_addr2 == waddr2)) mbusy[waddr2] = 1'b0;
            ec = '0;
            for (int i = 0; i < 8; i++) ec = ec + 4'(mbusy[i]);
            tick();
            chk("c_cnt", cnt2, ec);
        end
        we2 = 1'b0; issue2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
